// File: rtl/shift_right_seq_if.sv
// rtl/shift_right_seq_if.sv - start/busy/done handshake bundle for the iterative right shifter
interface shift_right_seq_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic               arith;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   data_in;
    logic [WIDTH-1:0]   data_out;
    logic               busy;
    logic               done;

    modport master (
        output start, arith, shamt, data_in,
        input  data_out, busy, done
    );

    modport slave (
        input  start, arith, shamt, data_in,
        output data_out, busy, done
    );
endinterface

// File: rtl/shift_right_seq.sv
// rtl/shift_right_seq.sv - iterative SRL/SRA unit, one bit position per clock
module shift_right_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    shift_right_seq_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_data_next;
    logic [SHAMT_W-1:0] r_count;
    logic [SHAMT_W-1:0] w_count_next;
    logic               r_arith;
    logic               w_arith_next;
    logic               w_fill;

    // Sign fill only when the captured op was arithmetic; MSB re-copies itself each step
    assign w_fill = r_arith & r_data[WIDTH-1];

    always_comb begin
        w_state_next = r_state;
        w_data_next  = r_data;
        w_count_next = r_count;
        w_arith_next = r_arith;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_data_next  = bus.data_in;
                    w_count_next = bus.shamt;
                    w_arith_next = bus.arith;
                    w_state_next = (bus.shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_data_next  = {w_fill, r_data[WIDTH-1:1]};
                w_count_next = r_count - SHAMT_W'(1);
                if (r_count == SHAMT_W'(1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_count <= '0;
            r_arith <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_data  <= w_data_next;
            r_count <= w_count_next;
            r_arith <= w_arith_next;
        end
    end

    // Status is decoded from registered state only, so start never reaches busy/done combinationally
    assign bus.data_out = r_data;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = (r_state == ST_DONE);
endmodule
